jam_ctrl: RTL

JAM_CTRL -- requirements
Module: jam_ctrl

---
 rtl/jam_pkg.sv | 20 ++
 rtl/jam_cost_rf.sv | 23 ++
 rtl/jam_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/jam_pkg.sv
// Shared types and sizes for the assignment-engine controller.
// No logic; widths of the cost table, result fields and the default watchdog limit.
package jam_pkg;
    localparam int N          = 8;
    localparam int IDX_W      = 3;
    localparam int ADDR_W     = 6;
    localparam int DEPTH      = 64;
    localparam int COST_W     = 7;
    localparam int MINCOST_W  = 10;
    localparam int MATCH_W    = 4;
    localparam int TIMEOUT_DEF = 500000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_RESULT = 3'd3,
        ST_ERR    = 3'd4
    } state_t;
endpackage

// File: rtl/jam_cost_rf.sv
// 64x7 cost table: one synchronous write port, one combinational read port.
// Write lands on the next rising edge; read is zero-latency; no backpressure.
module jam_cost_rf
    import jam_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COST_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COST_W-1:0] rd_dat
);
    // Contents are deliberately not reset; the controller's loaded flag gates use.
    logic [COST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/jam_ctrl.sv
// Controller: loads a 64-entry cost table, runs the engine under a watchdog, holds the result.
// ARM is 2 cycles; eng_cost is combinational; result held in RESULT until res_ready.
module jam_ctrl
    import jam_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_valid,
    input  logic [COST_W-1:0]    ld_data,
    output logic                 ld_ready,
    input  logic                 start,
    output logic                 busy,
    output logic                 eng_rst,
    input  logic [IDX_W-1:0]     eng_W,
    input  logic [IDX_W-1:0]     eng_J,
    output logic [COST_W-1:0]    eng_cost,
    input  logic [MINCOST_W-1:0] eng_mincost,
    input  logic [MATCH_W-1:0]   eng_matchcount,
    input  logic                 eng_valid,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [MINCOST_W-1:0] res_mincost,
    output logic [MATCH_W-1:0]   res_matchcount,
    output logic                 timeout
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t            state, state_nxt;
    logic              loaded;
    logic [ADDR_W-1:0] ld_cnt;
    logic              arm_cnt;
    logic [WD_W-1:0]   wdog;
    logic              wd_exp;
    logic              wr_en;
    logic              unload;
    logic [COST_W-1:0] rd_dat;

    assign wd_exp = (wdog == WD_W'(TIMEOUT - 1));
    assign wr_en  = ld_valid && ld_ready;
    assign unload = ((state == ST_RESULT) && res_ready) || ((state == ST_ERR) && start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start && loaded) state_nxt = ST_ARM;
            ST_ARM:    if (arm_cnt) state_nxt = ST_RUN;
            // A result arriving on the expiry cycle takes priority over the watchdog.
            ST_RUN: begin
                if (eng_valid) begin
                    state_nxt = ST_RESULT;
                end else if (wd_exp) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_RESULT: if (res_ready) state_nxt = ST_IDLE;
            ST_ERR:    if (start) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        eng_rst   = (state != ST_RUN);
        ld_ready  = (state == ST_IDLE) && !loaded;
        res_valid = (state == ST_RESULT);
        timeout   = (state == ST_ERR);
        eng_cost  = (state == ST_RUN) ? rd_dat : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded         <= 1'b0;
            ld_cnt         <= '0;
            arm_cnt        <= 1'b0;
            wdog           <= '0;
            res_mincost    <= '0;
            res_matchcount <= '0;
        end else begin
            arm_cnt <= (state == ST_ARM) ? ~arm_cnt : 1'b0;
            wdog    <= ((state == ST_RUN) && (state_nxt == ST_RUN)) ? wdog + 1'b1 : '0;
            if (unload) begin
                loaded <= 1'b0;
                ld_cnt <= '0;
            end else if (wr_en) begin
                ld_cnt <= ld_cnt + 1'b1;
                if (ld_cnt == ADDR_W'(DEPTH - 1)) begin
                    loaded <= 1'b1;
                end
            end
            if ((state == ST_RUN) && eng_valid) begin
                res_mincost    <= eng_mincost;
                res_matchcount <= eng_matchcount;
            end
        end
    end

    jam_cost_rf u_rf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ld_cnt),
        .wr_dat  (ld_data),
        .rd_addr ({eng_W, eng_J}),
        .rd_dat  (rd_dat)
    );
endmodule
